// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared types and defaults for the multiplier-sharing arbiter.
// Holds the FSM state enum, default sizes and the saturating stats helper.
package mult_share_pkg;

    localparam int DEF_N       = 32;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_MUL_LAT = 2;
    localparam int STATS_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(
        input logic [STATS_W-1:0] v
    );
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick among NREQ requests.
// The search starts one past last_grant and wraps around.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int GW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [GW-1:0]   grant_idx,
    output logic            any
);

    int            idx;
    logic [GW-1:0] idx_w;

    // Walk the requesters cyclically from last_grant+1; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last_grant) + k) % NREQ;
            idx_w = GW'(idx);
            if (!any && req[idx_w]) begin
                any       = 1'b1;
                grant_idx = idx_w;
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one registered multiplier among NREQ requesters.
// Define MULT_SHARE_ARBITER_STATS_EN to add op_count / ovf_count outputs.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NREQ    = DEF_NREQ,
    parameter int MUL_LAT = DEF_MUL_LAT,
    localparam int GW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [2*N-1:0]       resp_result,
    output logic                 resp_overflow,
    output logic [N-1:0]         mul_a,
    output logic [N-1:0]         mul_b,
    output logic                 mul_en,
    input  logic [2*N-1:0]       mul_result,
    input  logic                 mul_overflow
`ifdef MULT_SHARE_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0]   op_count,
    output logic [STATS_W-1:0]   ovf_count
`endif
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   tag;
    logic [GW-1:0]   last_grant;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;

    logic [NREQ-1:0] grant;
    logic [GW-1:0]   grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] tag_onehot;
    logic            resp_done;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    assign tag_onehot = {{(NREQ-1){1'b0}}, 1'b1} << tag;
    assign resp_done  = (state == RESP) && resp_ready[tag];

    // Control FSM: capture a granted operation, run the multiplier,
    // then hold the response until its owner accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tag        <= '0;
            last_grant <= GW'(NREQ - 1);
            op_a       <= '0;
            op_b       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a  <= req_a[int'(grant_idx) * N +: N];
                        op_b  <= req_b[int'(grant_idx) * N +: N];
                        tag   <= grant_idx;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[tag]) begin
                        last_grant <= tag;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: every output is a pure function of the current state,
    // except req_ready which follows the live arbitration in IDLE.
    always_comb begin
        req_ready     = '0;
        resp_valid    = '0;
        resp_result   = '0;
        resp_overflow = 1'b0;
        mul_en        = 1'b0;
        mul_a         = '0;
        mul_b         = '0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                end
            end
            RUN: begin
                mul_en = 1'b1;
                mul_a  = op_a;
                mul_b  = op_b;
            end
            RESP: begin
                resp_valid    = tag_onehot;
                resp_result   = mul_result;
                resp_overflow = mul_overflow;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

`ifdef MULT_SHARE_ARBITER_STATS_EN
    // Count completed operations and the ones that overflowed, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (resp_done) begin
            op_count <= sat_inc(op_count);
            if (mul_overflow) begin
                ovf_count <= sat_inc(ovf_count);
            end
        end
    end
`endif

endmodule
